seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes and a full flag set.
- Processes a WIDTH-bit operand pair as SLICE-bit chunks, LSB slice first, one slice per clock.
- Carry is held in a register between slices, trading latency for a short carry chain.
- Next-generation arithmetic core for the calculator datapath; replaces fixed 8-bit combinational add/sub.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥2.
- SLICE, 4, bits processed per cycle; WIDTH % SLICE == 0 is required, else elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- ovr  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

Behaviour:
- Reset, asynchronous on rst_n low:
  - State IDLE.
  - in_ready = 1; out_valid = 0.
  - sum, cout, ovr, zero, neg = 0; internal carry, slice index and operand registers = 0.
- Reset mid-operation aborts the operation; no partial result is ever presented.
- N = WIDTH/SLICE.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b^{WIDTH{sub}} and sub; carry register = sub; index = 0; go to CALC.
- CALC:
  - in_ready = 0.
  - Each cycle adds slice[index] of A, slice[index] of X and the carry register.
  - Writes the SLICE result bits into sum[index*SLICE +: SLICE], and the slice carry-out into the carry register.
  - On the final slice (index = N-1):
    - Capture carry into the MSB, from the internal bit WIDTH-2 carry.
    - cout = final carry; ovr = cin_msb ^ cout.
    - Go to DONE.
  - Otherwise index increments.
- DONE:
  - out_valid = 1.
  - zero and neg are computed from the final sum.
  - sum/flags are held stable while out_ready = 0.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency: out_valid rises exactly N cycles after the accepting edge.
- Throughput: one operation per N+2 cycles; no overlap.
- in_valid while in_ready = 0 is ignored; the producer must hold it.
- a, b and sub are sampled only at the accepting edge; later changes have no effect.
- sum and flags are don't-care outside DONE.
- When SLICE == WIDTH: N = 1 and ovr must still use the internal MSB carry-in.

Optional Feature:
- Macro SEQ_ADDSUB_SAT_EN.
- Defined: when ovr = 1 in DONE, sum is clamped to the saturated signed value.
  - Clamp to 2^(WIDTH-1)-1 (e.g. 0x7FFF) if latched A MSB = 0.
  - Clamp to -2^(WIDTH-1) (0x8000) if A MSB = 1.
  - ovr, cout and the internal carry are unchanged; zero and neg reflect the clamped sum.
  - Clamp is applied at the CALC→DONE transition with no extra cycle.
- Undefined: wrap-around result, no clamping logic.

Test Plan (WIDTH=16, SLICE=4, N=4):
1. Add 0x1234+0x0F0F, out_ready=1 → out_valid 4 cycles after accept; sum=0x2143, cout=0, ovr=0, zero=0, neg=0; in_ready back to 1 the cycle after the DONE handshake.
2. Sub 0x0005-0x0007 → sum=0xFFFE, cout=0, ovr=0, neg=1. Sub 0x1234-0x1234 → sum=0x0000, cout=1, zero=1.
3. Add 0x7FFF+0x0001 → ovr=1, cout=0; sum=0x8000, neg=1 without SAT; sum=0x7FFF, neg=0 with SEQ_ADDSUB_SAT_EN.
4. Sub 0x8000-0x0001 → ovr=1, cout=1; sum=0x7FFF without SAT; sum=0x8000 with SAT.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE → sum/flags/out_valid stable, in_ready=0; a second in_valid during CALC/DONE is not accepted until after the result handshake.
6. Assert rst_n low at CALC cycle 2 with operands changing → all outputs go to reset values immediately (asynchronous); after release, a fresh add 0xFFFF+0x0001 gives sum=0x0000, cout=1, zero=1, ovr=0.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement adder/subtractor, SLICE bits per clock with a registered carry.
// Define SEQ_ADDSUB_SAT_EN to clamp overflowing results to the signed saturation limit.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovr,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("seq_addsub: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, x_q, x_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovr_q, ovr_d, zero_q, zero_d, neg_q, neg_d;

  logic [SLICE-1:0] sa, sx, ss;
  logic             sc, cin_msb;
  int unsigned      base;

  always_comb begin
    base = 32'(idx_q) * 32'(SLICE);
    sa   = SLICE'(a_q >> base);
    sx   = SLICE'(x_q >> base);
    {sc, ss} = {1'b0, sa} + {1'b0, sx} + (SLICE+1)'(carry_q);
    // Carry into the MSB recovered from the top bit of the last slice.
    cin_msb = ss[SLICE-1] ^ sa[SLICE-1] ^ sx[SLICE-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovr_d   = ovr_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          x_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[base +: SLICE] = ss;
        carry_d = sc;
        if (idx_q == IW'(N - 1)) begin
          cout_d = sc;
          ovr_d  = cin_msb ^ sc;
`ifdef SEQ_ADDSUB_SAT_EN
          if (cin_msb ^ sc)
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          zero_d  = (sum_d == '0);
          neg_d   = sum_d[WIDTH-1];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovr_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovr_q   <= ovr_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovr       = ovr_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed cases, backpressure, async reset, random ops vs. an arithmetic model.
module tb_seq_addsub;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, ovr, zero, neg;

  int checks = 0;
  int errors = 0;

  seq_addsub #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovr(ovr), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       output logic [W+3:0] res);
    longint lim, ua, ub, va, vb, r, maxv, minv, ur;
    logic [W-1:0] s;
    logic c, o;
    lim  = longint'(1) << W;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    ua = longint'(ma);
    ub = longint'(mb);
    va = ma[W-1] ? ua - lim : ua;
    vb = mb[W-1] ? ub - lim : ub;
    r  = msub ? va - vb : va + vb;
    o  = (r > maxv) || (r < minv);
    c  = msub ? (ua >= ub) : (ua + ub >= lim);
    ur = msub ? ua - ub + lim : ua + ub;
    s  = W'(ur % lim);
`ifdef SEQ_ADDSUB_SAT_EN
    if (o) s = (r > 0) ? W'(maxv) : W'(minv);
`endif
    res = {s, c, o, (s == '0), s[W-1]};
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          output logic rdy);
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovr, zero, neg} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b sum=%h flags=%b%b%b%b required rdy=1 vld=0 sum=0000 flags=0000",
               in_ready, out_valid, sum, cout, ovr, zero, neg);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [7] = '{16'h1234, 16'h0005, 16'h1234, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    logic [W-1:0] tb [7] = '{16'h0F0F, 16'h0007, 16'h1234, 16'h0001, 16'h0001, 16'h0000, 16'h0001};
    logic         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    // expected {sum, cout, ovr, zero, neg}
`ifdef SEQ_ADDSUB_SAT_EN
    logic [W+3:0] ex [7] = '{{16'h2143, 4'b0000}, {16'hFFFE, 4'b0001}, {16'h0000, 4'b1010},
                             {16'h7FFF, 4'b0100}, {16'h8000, 4'b1101}, {16'h0000, 4'b1010},
                             {16'h0000, 4'b1010}};
`else
    logic [W+3:0] ex [7] = '{{16'h2143, 4'b0000}, {16'hFFFE, 4'b0001}, {16'h0000, 4'b1010},
                             {16'h8000, 4'b0101}, {16'h7FFF, 4'b1100}, {16'h0000, 4'b1010},
                             {16'h0000, 4'b1010}};
`endif
    logic rdy;
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      start_op(ta[i], tb[i], ts[i], rdy);
      wait_valid(cyc);
      checks++;
      if (!rdy || cyc != NS) begin
        errors++;
        $display("FAIL dir%0d latency: got rdy=%b cycles=%0d required rdy=1 cycles=%0d", i, rdy, cyc, NS);
      end
      checks++;
      if ({sum, cout, ovr, zero, neg} !== ex[i]) begin
        errors++;
        $display("FAIL dir%0d result: got %h required %h", i, {sum, cout, ovr, zero, neg}, ex[i]);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL dir%0d handshake: got vld=%b rdy=%b required vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W+3:0] e1, e2;
    logic rdy;
    int cyc;
    model(16'hA5A5, 16'h5A5B, 1'b0, e1);
    model(16'h0003, 16'h0009, 1'b1, e2);
    out_ready = 1'b0;
    start_op(16'hA5A5, 16'h5A5B, 1'b0, rdy);
    a = 16'h0003; b = 16'h0009; sub = 1'b1; in_valid = 1'b1;
    wait_valid(cyc);
    checks++;
    if (!rdy || cyc != NS || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp first: got rdy=%b cycles=%0d in_ready=%b required 1 %0d 0", rdy, cyc, in_ready, NS);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, sum, cout, ovr, zero, neg} !== {2'b10, e1}) begin
        errors++;
        $display("FAIL bp hold%0d: got %h required %h", k, {out_valid, in_ready, sum, cout, ovr, zero, neg}, {2'b10, e1});
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp second accept: got in_ready=%b required 0", in_ready);
    end
    @(negedge clk); in_valid = 1'b0;
    wait_valid(cyc);
    checks++;
    if (cyc != NS || {sum, cout, ovr, zero, neg} !== e2) begin
      errors++;
      $display("FAIL bp second result: got cycles=%0d %h required cycles=%0d %h", cyc, {sum, cout, ovr, zero, neg}, NS, e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    logic rdy;
    int cyc;
    out_ready = 1'b1;
    start_op(16'h1111, 16'h2222, 1'b0, rdy);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovr, zero, neg} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0}) begin
      errors++;
      $display("FAIL async reset: got rdy=%b vld=%b sum=%h flags=%b%b%b%b required rdy=1 vld=0 sum=0000 flags=0000",
               in_ready, out_valid, sum, cout, ovr, zero, neg);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset no partial: got out_valid=%b required 0", out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    start_op(16'hFFFF, 16'h0001, 1'b0, rdy);
    wait_valid(cyc);
    checks++;
    if (!rdy || cyc != NS || {sum, cout, ovr, zero, neg} !== {16'h0000, 4'b1010}) begin
      errors++;
      $display("FAIL post-reset add: got rdy=%b cycles=%0d %h required 1 %0d %h",
               rdy, cyc, {sum, cout, ovr, zero, neg}, NS, {16'h0000, 4'b1010});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic rs, rdy;
    logic [W+3:0] e;
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
      if (i % 8 == 1) ra = {1'b1, {(W-1){1'b0}}};
      if (i % 8 == 2) rb = ra;
      model(ra, rb, rs, e);
      start_op(ra, rb, rs, rdy);
      wait_valid(cyc);
      checks++;
      if (!rdy || cyc != NS || {sum, cout, ovr, zero, neg} !== e) begin
        errors++;
        $display("FAIL rand%0d %h%s%h: got rdy=%b cycles=%0d %h required 1 %0d %h",
                 i, ra, rs ? "-" : "+", rb, rdy, cyc, {sum, cout, ovr, zero, neg}, NS, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
